// File: rtl/cmd_issuer.sv
// cmd_issuer: assembles little-endian 32-bit command words from a host byte
// stream, buffers them in a small FIFO and replays each word to the graphics
// pipeline as a one-cycle o_cmd_clk strobe with o_cmd_data held stable around it.
// Optional feature: define CMD_ISSUER_BLANK_ONLY_EN to issue commands only
// while i_blank is high (commands queue during active video).
module cmd_issuer #(
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             i_byte_valid,
   input  logic             i_byte_sof,
   input  logic [7:0]       i_byte_data,
   output logic             o_byte_ready,
   input  logic             i_blank,
   output logic             o_cmd_clk,
   output logic [31:0]      o_cmd_data,
   output logic [LVL_W-1:0] o_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   logic [1:0]       r_byte_cnt;
   logic [23:0]      r_asm;
   logic [31:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   state_t           r_state;
   logic             r_cmd_clk;
   logic [31:0]      r_cmd_data;

   logic             w_full;
   logic             w_empty;
   logic             w_ready;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_permit;
   logic [31:0]      w_word;

   assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty  = (r_level == '0);
   // The last byte of a word is held off while the FIFO is full, so a push
   // can never overflow.
   assign w_ready  = (r_byte_cnt != 2'd3) || !w_full;
   assign w_accept = i_byte_valid && w_ready;
   assign w_push   = w_accept && !i_byte_sof && (r_byte_cnt == 2'd3);
   assign w_word   = {i_byte_data, r_asm};

`ifdef CMD_ISSUER_BLANK_ONLY_EN
   assign w_permit = i_blank;
`else
   logic w_unused_blank;
   assign w_unused_blank = i_blank;
   assign w_permit       = 1'b1;
`endif

   assign w_pop = (r_state == ST_IDLE) && !w_empty && w_permit;

   // Byte assembler: sof always restarts the word at byte 0.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_byte_cnt <= 2'd0;
         r_asm      <= '0;
      end else if (w_accept) begin
         if (i_byte_sof) begin
            r_asm[7:0] <= i_byte_data;
            r_byte_cnt <= 2'd1;
         end else begin
            case (r_byte_cnt)
               2'd0:    r_asm[7:0]   <= i_byte_data;
               2'd1:    r_asm[15:8]  <= i_byte_data;
               2'd2:    r_asm[23:16] <= i_byte_data;
               default: ;  // byte 3 goes straight into the FIFO
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
      end
   end

   // FIFO storage write port.
   // NOTE: the storage array is deliberately not reset; only the pointers and
   // level are, which makes stale contents unreachable and keeps it a plain RAM.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: ;
         endcase
      end
   end

   // Issue FSM: pop in IDLE, then SETUP / STROBE / HOLD with registered outputs.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state    <= ST_IDLE;
         r_cmd_clk  <= 1'b0;
         r_cmd_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cmd_clk <= 1'b0;
               if (w_pop) begin
                  r_cmd_data <= r_mem[r_rd_ptr];
                  r_state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_cmd_clk <= 1'b1;
               r_state   <= ST_STROBE;
            end
            ST_STROBE: begin
               r_cmd_clk <= 1'b0;
               r_state   <= ST_HOLD;
            end
            default: begin
               r_cmd_clk <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_byte_ready = w_ready;
   assign o_cmd_clk    = r_cmd_clk;
   assign o_cmd_data   = r_cmd_data;
   assign o_level      = r_level;

endmodule

// File: tb/tb_cmd_issuer.sv
// Testbench for cmd_issuer: directed scenarios plus randomized byte traffic,
// checked against a transaction-level reference model and a word scoreboard.
module tb_cmd_issuer;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             clk_i = 1'b0;
   logic             rstn_i = 1'b0;
   logic             i_byte_valid = 1'b0;
   logic             i_byte_sof = 1'b0;
   logic [7:0]       i_byte_data = 8'h00;
   logic             i_blank = 1'b0;
   logic             o_byte_ready;
   logic             o_cmd_clk;
   logic [31:0]      o_cmd_data;
   logic [LVL_W-1:0] o_level;

   cmd_issuer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .i_byte_valid (i_byte_valid),
      .i_byte_sof   (i_byte_sof),
      .i_byte_data  (i_byte_data),
      .o_byte_ready (o_byte_ready),
      .i_blank      (i_blank),
      .o_cmd_clk    (o_cmd_clk),
      .o_cmd_data   (o_cmd_data),
      .o_level      (o_level)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   int          m_cnt;        // bytes of the current word collected so far
   logic [7:0]  m_b [4];
   logic [31:0] m_fifo [$];   // words waiting to be issued
   int          m_ph;         // 0 idle, else cycles since the pop (1..3)
   logic [31:0] m_data;       // last command word presented
   logic [31:0] sb_q [$];     // scoreboard: words expected on strobes, in order
   int          m_size;
   bit          m_rdy;
   bit          m_pop;

   function automatic bit permit();
`ifdef CMD_ISSUER_BLANK_ONLY_EN
      return i_blank;
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         m_cnt  = 0;
         m_fifo.delete();
         sb_q.delete();
         m_ph   = 0;
         m_data = 32'h0;
      end else begin
         m_size = m_fifo.size();
         m_rdy  = (m_cnt != 3) || (m_size != DEPTH);
         m_pop  = (m_ph == 0) && (m_size > 0) && permit();
         if (m_pop) begin
            m_data = m_fifo.pop_front();
            m_ph   = 1;
         end else if (m_ph != 0) begin
            m_ph = (m_ph + 1) % 4;
         end
         if (i_byte_valid && m_rdy) begin
            if (i_byte_sof) begin
               m_b[0] = i_byte_data;
               m_cnt  = 1;
            end else begin
               m_b[m_cnt] = i_byte_data;
               if (m_cnt == 3) begin
                  m_fifo.push_back({m_b[3], m_b[2], m_b[1], m_b[0]});
                  sb_q.push_back({m_b[3], m_b[2], m_b[1], m_b[0]});
               end
               m_cnt = (m_cnt + 1) % 4;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   int          strobe_cnt = 0;
   logic [31:0] last_cmd   = 32'h0;

   always @(negedge clk_i) begin
      if (rstn_i) begin
         check("level", 32'(o_level), 32'(m_fifo.size()));
         check("byte_ready", 32'(o_byte_ready), 32'((m_cnt != 3) || (m_fifo.size() != DEPTH)));
         check("cmd_clk", 32'(o_cmd_clk), 32'(m_ph == 2));
         check("cmd_data_hold", o_cmd_data, m_data);
         if (o_cmd_clk) begin
            strobe_cnt++;
            last_cmd = o_cmd_data;
            if (sb_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
            else                  check("strobe_word", o_cmd_data, sb_q.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] data, input logic sof);
      bit ok = 1'b0;
      @(negedge clk_i);
      i_byte_valid = 1'b1;
      i_byte_sof   = sof;
      i_byte_data  = data;
      for (int i = 0; i < 200; i++) begin
         #1 ok = o_byte_ready;
         @(posedge clk_i);
         if (ok) break;
         @(negedge clk_i);
      end
      if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0], 1'b1);
      send_byte(w[15:8], 1'b0);
      send_byte(w[23:16], 1'b0);
      send_byte(w[31:24], 1'b0);
   endtask

   task automatic idle();
      @(negedge clk_i);
      i_byte_valid = 1'b0;
      i_byte_sof   = 1'b0;
   endtask

   // First-word latency: level 1 one cycle after the 4th byte, data at +2, strobe at +3.
   task automatic run_latency(input logic blank);
      int s0;
      i_blank = blank;
      s0 = strobe_cnt;
      send_word(32'h44332211);
      idle();
      check("lat_level_n1", 32'(o_level), 32'd1);
      check("lat_clk_n1", 32'(o_cmd_clk), 32'd0);
      @(negedge clk_i);
      check("lat_level_n2", 32'(o_level), 32'd0);
      check("lat_data_n2", o_cmd_data, 32'h44332211);
      check("lat_clk_n2", 32'(o_cmd_clk), 32'd0);
      @(negedge clk_i);
      check("lat_clk_n3", 32'(o_cmd_clk), 32'd1);
      @(negedge clk_i);
      check("lat_clk_n4", 32'(o_cmd_clk), 32'd0);
      check("lat_data_n4", o_cmd_data, 32'h44332211);
      repeat (4) @(negedge clk_i);
      check("lat_one_strobe", 32'(strobe_cnt - s0), 32'd1);
   endtask

   initial begin
      int s0;
      logic [31:0] words [6];

      // reset
      i_blank = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_cmd_clk", 32'(o_cmd_clk), 32'd0);
      check("rst_cmd_data", o_cmd_data, 32'h0);
      check("rst_level", 32'(o_level), 32'd0);
      check("rst_ready", 32'(o_byte_ready), 32'd1);
      #2 rstn_i = 1'b1;

      // basic word and latency
      run_latency(1'b1);
`ifndef CMD_ISSUER_BLANK_ONLY_EN
      run_latency(1'b0);
`endif

      // resync: partial word dropped
      i_blank = 1'b1;
      s0 = strobe_cnt;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b0);
      send_word(32'h04030201);
      idle();
      repeat (10) @(negedge clk_i);
      check("resync_strobes", 32'(strobe_cnt - s0), 32'd1);
      check("resync_word", last_cmd, 32'h04030201);
      check("resync_level", 32'(o_level), 32'd0);

`ifdef CMD_ISSUER_BLANK_ONLY_EN
      // saturation while issue is blocked, then drain in order
      i_blank = 1'b0;
      s0 = strobe_cnt;
      for (int k = 0; k < 6; k++) words[k] = $urandom;
      for (int k = 0; k < 4; k++) send_word(words[k]);
      send_byte(words[4][7:0], 1'b1);
      send_byte(words[4][15:8], 1'b0);
      send_byte(words[4][23:16], 1'b0);
      idle();
      check("sat_level", 32'(o_level), 32'd4);
      check("sat_ready", 32'(o_byte_ready), 32'd0);
      check("sat_no_strobe", 32'(strobe_cnt - s0), 32'd0);
      fork
         begin
            repeat (6) @(negedge clk_i);
            i_blank = 1'b1;
         end
         send_byte(words[4][31:24], 1'b0);
      join
      send_word(words[5]);
      idle();
      repeat (30) @(negedge clk_i);
      check("drain_strobes", 32'(strobe_cnt - s0), 32'd6);
      check("drain_last", last_cmd, words[5]);
      check("drain_level", 32'(o_level), 32'd0);

      // blank falls during SETUP: strobe completes, next word waits
      i_blank = 1'b0;
      send_word(32'hC0DE0001);
      send_word(32'hC0DE0002);
      idle();
      s0 = strobe_cnt;
      i_blank = 1'b1;
      @(negedge clk_i);
      i_blank = 1'b0;
      repeat (10) @(negedge clk_i);
      check("blank_fall_strobes", 32'(strobe_cnt - s0), 32'd1);
      check("blank_fall_word", last_cmd, 32'hC0DE0001);
      check("blank_fall_level", 32'(o_level), 32'd1);
      i_blank = 1'b1;
      repeat (8) @(negedge clk_i);
      check("blank_rise_strobes", 32'(strobe_cnt - s0), 32'd2);
      check("blank_rise_word", last_cmd, 32'hC0DE0002);
`endif

      // reset during STROBE with a partial word pending
      i_blank = 1'b1;
      send_word(32'hDEADBEEF);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b0);
      #1 check("strobe_before_rst", 32'(o_cmd_clk), 32'd1);
      rstn_i = 1'b0;
      #1;
      check("mid_rst_cmd_clk", 32'(o_cmd_clk), 32'd0);
      check("mid_rst_cmd_data", o_cmd_data, 32'h0);
      check("mid_rst_level", 32'(o_level), 32'd0);
      idle();
      #2 rstn_i = 1'b1;
      s0 = strobe_cnt;
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b0);
      idle();
      repeat (12) @(negedge clk_i);
      check("post_rst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
      check("post_rst_level", 32'(o_level), 32'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_i);
         i_byte_valid = ($urandom_range(0, 3) != 0);
         i_byte_sof   = ($urandom_range(0, 9) == 0);
         i_byte_data  = 8'($urandom);
         if ($urandom_range(0, 19) == 0) i_blank = ~i_blank;
      end
      i_byte_valid = 1'b0;
      i_byte_sof   = 1'b0;
      i_blank      = 1'b1;
      repeat (40) @(negedge clk_i);
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      check("final_level", 32'(o_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cmd_issuer.md
# cmd_issuer

Host-side command initiator for the text-area command port. Accepts a byte stream from a host interface, assembles little-endian 32-bit command words, buffers them in a small FIFO and replays each one to the graphics pipeline as a single-cycle `cmd_clk` strobe with stable `cmd_data`. It sits in the top level between the host interface and the text area's `i_cmd_clk`/`i_cmd_data` inputs, running in the pixel-clock domain.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command words buffered; power of two, at least 2.
- `LVL_W`, `$clog2(FIFO_DEPTH)+1`: width of `o_level`.

Ports:
- `clk_i`  in  1  pixel clock; all logic on the rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `i_byte_valid`  in  1  host byte present.
- `i_byte_sof`  in  1  qualifies `i_byte_valid`: this byte is byte 0 of a command.
- `i_byte_data`  in  8  host byte.
- `o_byte_ready`  out  1  byte accepted when `i_byte_valid && o_byte_ready`.
- `i_blank`  in  1  display blanking, high outside the active area.
- `o_cmd_clk`  out  1  command strobe, one cycle high per command.
- `o_cmd_data`  out  32  command word.
- `o_level`  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Assembler: 2-bit `byte_cnt`. An accepted byte is written to bits `[8*byte_cnt+7 : 8*byte_cnt]` of the assembly register. `byte_cnt` then increments and wraps 3->0. When the byte with `byte_cnt==3` is accepted, the full word is pushed into the FIFO.
- Resync: an accepted byte with `i_byte_sof=1` is always treated as byte 0. Any partial word is discarded and `byte_cnt` becomes 1. `i_byte_sof` on a non-accepted cycle is ignored.
- `o_byte_ready = (byte_cnt != 3) || (o_level != FIFO_DEPTH)`. The final byte of a word is never accepted into a full FIFO, so there is no overflow path.
- Issue FSM, states IDLE -> SETUP -> STROBE -> HOLD -> IDLE:
  - IDLE: if the FIFO is non-empty and issue is permitted, pop the head into `o_cmd_data` and go to SETUP.
  - SETUP: one cycle, data settles, `o_cmd_clk=0`.
  - STROBE: `o_cmd_clk=1` for exactly one cycle.
  - HOLD: one cycle, `o_cmd_clk=0`, data held.
- `o_cmd_data` changes only on the IDLE->SETUP transition. Otherwise it retains the last command indefinitely.
- Push and pop in the same cycle are both performed; `o_level` stays unchanged.

## Timing
- Reset values: `o_cmd_clk=0`, `o_cmd_data=0`, `o_level=0`, `o_byte_ready=1`, `byte_cnt=0`, FSM in IDLE, FIFO pointers 0.
- Push-to-issue latency, FIFO empty and issue permitted:
  - 4th byte accepted at cycle N.
  - `o_level=1` at N+1.
  - Pop at N+1 edge, `o_cmd_data` valid at N+2 (SETUP).
  - `o_cmd_clk` high at N+3.
- Throughput: one command per 4 cycles. Back-to-back commands give a `o_cmd_clk` period of 4 cycles.
- `o_cmd_data` is stable at least one cycle before, during, and one cycle after `o_cmd_clk`.
- Once the FSM leaves IDLE, the sequence completes regardless of `i_blank` or FIFO state.
- Reset mid-sequence, including during STROBE: all outputs return to reset values asynchronously, and the FIFO contents and partial word are lost.

## Configuration
- `CMD_ISSUER_BLANK_ONLY_EN` defined:
  - Issue is permitted only when `i_blank=1` is sampled in IDLE.
  - Commands queue during active video and drain during blanking.
- Not defined:
  - Issue is always permitted.
  - `i_blank` is unused.

## Test plan
- Reset, then bytes 0x11, 0x22, 0x33, 0x44 (first with sof) -> `o_cmd_data=0x44332211` and a single `o_cmd_clk` pulse 3 cycles after the 4th byte. `o_level` goes 0 -> 1 -> 0.
- Sequence 0xAA(sof), 0xBB, then 0x01(sof), 0x02, 0x03, 0x04 -> exactly one command, `0x04030201`. The partial word is dropped.
- Six back-to-back words, no issue permitted (macro defined, `i_blank=0`) -> `o_level` saturates at 4 and `o_byte_ready` drops on the 4th byte of word 5. Raising `i_blank` drains the words in order with strobes 4 cycles apart.
- Macro defined, `i_blank` falls during SETUP -> strobe still issued. Next queued command waits for `i_blank=1`.
- Assert `rstn_i=0` during STROBE -> `o_cmd_clk=0` and `o_cmd_data=0` immediately. After release, `o_level=0` and no strobe occurs.
- Macro undefined, `i_blank` held 0 -> word issued with the same 3-cycle latency as the first scenario.
